// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: DATA_BITS data bits, optional odd/even parity,
// 1 or 2 stop bits, paced by an external one-cycle baud_en tick.
module uart_tx_cfg #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_en,
    input  logic                 baud_en,
    output logic                 tx,
    output logic                 tx_rdy,
    output logic                 tx_done
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9, got %0d", DATA_BITS);
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2, got %0d", PARITY);
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2, got %0d", STOP_BITS);
    end

    localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic       STOP_LAST  = (STOP_BITS == 2);
    localparam bit         HAS_PARITY = (PARITY != 0);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t                state;
    logic [DATA_BITS-1:0]  shreg;
    logic [3:0]            bit_cnt;
    logic                  stop_cnt;
    logic                  par_bit;
    logic                  par_calc;

    always_comb begin
        par_calc = (PARITY == 1) ? ~(^tx_data) : ^tx_data;
    end

    // tx is registered and loaded with the value of the bit being entered,
    // so it moves exactly one cycle after the sampled baud_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            tx_rdy   <= 1'b1;
            tx_done  <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx     <= 1'b1;
                    tx_rdy <= 1'b1;
                    if (tx_en) begin
                        shreg   <= tx_data;
                        par_bit <= par_calc;
                        tx_rdy  <= 1'b0;
                        state   <= ARMED;
                    end
                end
                ARMED: begin
                    if (baud_en) begin
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_en) begin
                        tx      <= shreg[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_en) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            stop_cnt <= 1'b0;
                            if (HAS_PARITY) begin
                                tx    <= par_bit;
                                state <= PAR;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            tx <= shreg[1];
                        end
                    end
                end
                PAR: begin
                    if (baud_en) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (baud_en) begin
                        if (stop_cnt == STOP_LAST) begin
                            tx_done <= 1'b1;
                            tx_rdy  <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter.
- Configurable data width, parity mode and stop-bit count.
- Latches the data word at accept, so the frame is immune to later tx_data changes.
- Gives a one-cycle completion pulse.
- Sits between the host-side byte source and the serial pin, paced by the shared external baud_en tick generator.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.
Illegal values must trigger an elaboration-time error.

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  synchronous, active-high reset.
tx_data  input  DATA_BITS  word to send; sampled only at accept.
tx_en  input  1  send request; accepted when tx_en && tx_rdy.
baud_en  input  1  one-cycle baud tick, one per bit period (may be tied high).
tx  output  1  serial line, registered, idle high.
tx_rdy  output  1  high only in IDLE; block can accept a word.
tx_done  output  1  one-cycle pulse when a frame's last stop bit completes.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high. All state, counters and outputs are registered.
- Reset values:
  - state = IDLE, tx = 1, tx_rdy = 1, tx_done = 0.
  - Shift register, bit counter and parity register = 0.
- States: IDLE, ARMED, START, DATA, PAR, STOP.
- IDLE
  - tx = 1, tx_rdy = 1.
  - On tx_en = 1: latch tx_data into the shift register and compute the parity bit (even: XOR of data bits; odd: inverted XOR).
  - Next cycle: ARMED, tx_rdy = 0.
  - baud_en is ignored in IDLE. tx_en and baud_en in the same cycle still go to ARMED.
- ARMED
  - tx = 1; wait for baud_en, then go to START.
  - Guarantees every bit, including START, lasts a full baud period.
- START
  - tx = 0; on baud_en go to DATA with bit counter = 0.
- DATA
  - tx = shift register LSB (LSB first).
  - On baud_en, shift right and increment the counter.
  - When counter == DATA_BITS-1 and baud_en: go to PAR if PARITY != 0, else to STOP. Reset the stop counter to 0 on that transition.
- PAR
  - tx = parity bit; on baud_en go to STOP.
- STOP
  - tx = 1. On baud_en, if stop counter == STOP_BITS-1, go to IDLE; otherwise increment the stop counter.
  - On the transition to IDLE, tx_done = 1 for exactly that first IDLE cycle, and tx_rdy = 1 in the same cycle.
- tx changes only on the clock edge that changes the state or shifts data. It is glitch-free and updates one cycle after the sampled baud_en.
- Frame length = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS baud periods.
- While tx_rdy = 0: tx_en is ignored (no queuing), and tx_data changes have no effect on the frame in flight.
- rst asserted in any state (including mid-frame):
  - Next cycle, all reset values apply and tx = 1.
  - The frame is aborted and no tx_done is produced.
- baud_en tied high: each bit lasts 1 clk. Minimum frame-to-frame gap = 2 cycles of tx = 1 (one IDLE cycle plus one ARMED cycle) beyond the final stop bit.

Test Plan:
1. Defaults (8, N, 1), baud_en every 4 cycles, tx_data = 0xA5, tx_en one cycle.
   -> tx sequence 0, 1,0,1,0,0,1,0,1, 1, each bit held 4 cycles.
   -> tx_rdy low from the cycle after accept until tx_done.
   -> exactly one tx_done pulse.
2. PARITY = 2, tx_data = 0x07 -> parity bit 1. PARITY = 1, tx_data = 0x07 -> parity bit 0. Both frames are 11 bit periods.
3. DATA_BITS = 7, STOP_BITS = 2, PARITY = 0, tx_data = 0x55.
   -> 0, 1,0,1,0,1,0,1, 1,1.
   -> tx_done after the second stop period only.
4. Accept 0x3C, then change tx_data to 0xFF and pulse tx_en mid-frame.
   -> serialized bits stay those of 0x3C; no second frame starts.
5. Assert rst for one cycle during data bit 3.
   -> next cycle: tx = 1, tx_rdy = 1, tx_done = 0, state IDLE.
   -> a fresh 0x81 frame afterwards is correct.
6. baud_en tied high, tx_en held high, words 0x12 then 0x34 applied on accept.
   -> two correct 10-cycle frames.
   -> exactly 2 tx = 1 cycles between the first stop bit and the second start bit.
   -> two tx_done pulses.
